quad_step_decoder: RTL and testbench

- Conditions a 2-phase quadrature encoder (pins A/B) into clean single-cycle count steps plus a direction level.
- Sits directly upstream of the 4-bit up/down counter. step drives the counter's count enable; up_down drives its up_down input.
- Contains a 2-flop synchronizer, a per-channel glitch filter and a phase-tracking FSM. Illegal 2-bit phase jumps are reported on err.

---
 rtl/quad_pkg.sv | 13 +
 rtl/quad_glitch_filter.sv | 30 +++
 rtl/quad_step_decoder.sv | 76 +++++++
 tb/tb_quad_step_decoder.sv | 111 +++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// quad_pkg: phase codes, FSM state type and up-order successor lookup for quad_step_decoder
package quad_pkg;
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;
  typedef enum logic {INIT, TRACK} state_t;
  function automatic logic [1:0] next_up(input logic [1:0] phase);
    return phase == PH_00 ? PH_10 :
           phase == PH_10 ? PH_11 :
           phase == PH_11 ? PH_01 : PH_00;
  endfunction
endpackage

// File: rtl/quad_glitch_filter.sv
// quad_glitch_filter: 2-flop synchronizer plus run-length glitch filter for one encoder channel
module quad_glitch_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic bypass,
  output logic filt
);
  localparam int FILT_W = $clog2(FILT_LEN + 3);
  logic s1, s2;
  logic [FILT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      // a level is accepted only after FILT_LEN consecutive differing cycles
      if (bypass || s2 == filt || cnt == FILT_W'(FILT_LEN - 1)) begin
        filt <= s2;
        cnt  <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature A/B to step/up_down/err conditioner; define QUAD_X1_EN for x1 decoding
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  output logic step,
  output logic up_down,
  output logic err,
  output logic armed
);
  localparam int FILT_W = $clog2(FILT_LEN + 3);
  state_t state, state_n;
  logic [FILT_W-1:0] init_cnt, init_cnt_n;
  logic [1:0] p, prev, prev_n;
  logic filt_a, filt_b, is_up, is_dn, fire;
  logic step_n, err_n, up_down_n, armed_n;
  quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_a (
    .clk(clk), .reset(reset), .pin(a_in), .bypass(state == INIT), .filt(filt_a)
  );
  quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_b (
    .clk(clk), .reset(reset), .pin(b_in), .bypass(state == INIT), .filt(filt_b)
  );
  assign p     = {filt_a, filt_b};
  assign is_up = next_up(prev) == p;
  assign is_dn = next_up(p) == prev;
`ifdef QUAD_X1_EN
  assign fire = p == PH_00;
`else
  assign fire = 1'b1;
`endif
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    prev_n     = prev;
    step_n     = 1'b0;
    err_n      = 1'b0;
    up_down_n  = up_down;
    armed_n    = armed;
    if (state == INIT) begin
      init_cnt_n = init_cnt + 1'b1;
      if (init_cnt == FILT_W'(FILT_LEN + 1)) begin
        state_n = TRACK;
        prev_n  = p;
        armed_n = 1'b1;
      end
    end else if (p != prev) begin
      prev_n    = p;
      err_n     = !(is_up || is_dn);
      step_n    = (is_up || is_dn) && fire;
      up_down_n = step_n ? is_up : up_down;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
      prev     <= PH_00;
      step     <= 1'b0;
      err      <= 1'b0;
      up_down  <= 1'b1;
      armed    <= 1'b0;
    end else begin
      state    <= state_n;
      init_cnt <= init_cnt_n;
      prev     <= prev_n;
      step     <= step_n;
      err      <= err_n;
      up_down  <= up_down_n;
      armed    <= armed_n;
    end
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed self-checking bench for quad_step_decoder (FILT_LEN = 4, x4 build)
module tb_quad_step_decoder;
  logic clk = 1'b0, reset = 1'b1, a_in = 1'b1, b_in = 1'b1;
  logic step, up_down, err, armed;
  int checks = 0, failures = 0;
  int n_step, n_err, first_step, first_err, both;
  logic ud_first;
  quad_step_decoder #(.FILT_LEN(4)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
    .step(step), .up_down(up_down), .err(err), .armed(armed)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic run(input int n);
    n_step = 0; n_err = 0; first_step = -1; first_err = -1; both = 0; ud_first = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (step && err) both++;
      if (step) begin
        n_step++;
        if (first_step < 0) begin first_step = i; ud_first = up_down; end
      end
      if (err) begin
        n_err++;
        if (first_err < 0) first_err = i;
      end
    end
  endtask
  task automatic hold(input string tag, input logic a, input logic b,
                      input int e_steps, input int e_first, input int e_ud, input int e_err);
    a_in = a; b_in = b;
    run(10);
    chk({tag, "_steps"}, n_step, e_steps);
    chk({tag, "_first"}, e_err > 0 ? first_err : first_step, e_steps + e_err > 0 ? 7 : -1);
    chk({tag, "_ud"}, int'(up_down), e_ud);
    chk({tag, "_err"}, n_err, e_err);
    chk({tag, "_both"}, both, 0);
  endtask
  initial begin
    run(2);
    chk("rst_step", int'(step), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_ud", int'(up_down), 1);
    reset = 1'b0;
    run(5);
    chk("init_armed5", int'(armed), 0);
    chk("init_steps", n_step + n_err, 0);
    run(1);
    chk("init_armed6", int'(armed), 1);
    chk("init_ud", int'(up_down), 1);
    hold("to01", 1'b0, 1'b1, 1, 7, 1, 0);
    hold("to00", 1'b0, 1'b0, 1, 7, 1, 0);
    hold("up10", 1'b1, 1'b0, 1, 7, 1, 0);
    hold("up11", 1'b1, 1'b1, 1, 7, 1, 0);
    hold("up01", 1'b0, 1'b1, 1, 7, 1, 0);
    hold("up00", 1'b0, 1'b0, 1, 7, 1, 0);
    hold("dn01", 1'b0, 1'b1, 1, 7, 0, 0);
    hold("dn11", 1'b1, 1'b1, 1, 7, 0, 0);
    hold("dn10", 1'b1, 1'b0, 1, 7, 0, 0);
    hold("rev11", 1'b1, 1'b1, 1, 7, 1, 0);
    hold("back01", 1'b0, 1'b1, 1, 7, 1, 0);
    hold("back00", 1'b0, 1'b0, 1, 7, 1, 0);
    a_in = 1'b1;
    run(3);
    a_in = 1'b0;
    run(10);
    chk("g3_steps", n_step, 0);
    chk("g3_err", n_err, 0);
    chk("g3_filt_a", int'(dut.u_a.filt), 0);
    a_in = 1'b1;
    run(4);
    chk("g4_early", n_step, 0);
    a_in = 1'b0;
    run(12);
    chk("g4_steps", n_step, 2);
    chk("g4_first", first_step, 3);
    chk("g4_ud_first", int'(ud_first), 1);
    chk("g4_ud_last", int'(up_down), 0);
    chk("g4_err", n_err, 0);
    hold("jump11", 1'b1, 1'b1, 0, -1, 0, 1);
    hold("after01", 1'b0, 1'b1, 1, 7, 1, 0);
    hold("pre11", 1'b1, 1'b1, 1, 7, 0, 0);
    a_in = 1'b0;
    run(3);
    reset = 1'b1;
    run(1);
    chk("mrst_step", int'(step), 0);
    chk("mrst_err", int'(err), 0);
    chk("mrst_armed", int'(armed), 0);
    chk("mrst_ud", int'(up_down), 1);
    run(1);
    reset = 1'b0;
    run(5);
    chk("mrst_armed5", int'(armed), 0);
    chk("mrst_quiet5", n_step + n_err, 0);
    run(1);
    chk("mrst_armed6", int'(armed), 1);
    run(10);
    chk("mrst_quiet", n_step + n_err, 0);
    hold("final00", 1'b0, 1'b0, 1, 7, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
